sccb_config_sequencer: RTL
==========================

Name: sccb_config_sequencer

Overview:
- Walks a camera register-init table held in an external synchronous ROM and issues one SCCB write per entry to the existing SCCB write engine (start/address/data/ready interface).
- Supports an inline delay entry and an end marker, and counts completed writes.
- Times out the SCCB handshake and flags an error.
- Sits between the camera ROM and the SCCB engine; started once after power-up, or by software to re-initialise.

Parameters:
- ROM_AW, 8, ROM address width; the table holds at most 2^ROM_AW entries.
- DELAY_CYCLES, 250000, clk cycles waited on a delay entry (10 ms at 25 MHz).
- ACCEPT_TIMEOUT, 16, max cycles from sccb_start until sccb_ready is seen low.
- XFER_TIMEOUT, 1000000, max cycles in WAIT_HIGH for sccb_ready to return high.

Ports:
- clk  in  1  system clock, same domain as the SCCB engine.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run the table; honoured only in IDLE.
- rom_addr  out  ROM_AW  table address; ROM data is valid one cycle after rom_addr changes.
- rom_data  in  16  {reg_addr[15:8], reg_data[7:0]}; 16'hFFFF = end marker; 16'hFFF0 = delay entry.
- sccb_ready  in  1  ready output of the SCCB engine (1 = idle).
- sccb_start  out  1  one-cycle write request to the SCCB engine.
- sccb_address  out  8  register address, held stable from ISSUE until the next DECODE.
- sccb_data  out  8  register data, held with sccb_address.
- busy  out  1  high from the cycle after an accepted start until DONE or ERROR.
- done  out  1  sticky; set on normal completion, cleared by the next accepted start.
- error  out  1  sticky; set on timeout, cleared by the next accepted start.
- write_count  out  ROM_AW+1  number of SCCB writes completed in the current run.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rom_addr=0, sccb_start=0, sccb_address=0, sccb_data=0, busy=0, done=0, error=0, write_count=0, timers=0. A reset mid-transfer drops sccb_start immediately; the SCCB engine finishes its frame on its own.
- All outputs are registered.
- IDLE: on start=1, set rom_addr=0, busy=1, done=0, error=0, write_count=0, go to FETCH. start is ignored in all other states.
- FETCH: one wait cycle for ROM latency, then DECODE.
- DECODE: samples rom_data.
  - 16'hFFFF → DONE.
  - 16'hFFF0 → load the delay counter with DELAY_CYCLES-1, go to DELAY.
  - Otherwise latch sccb_address/sccb_data, go to ISSUE.
- ISSUE: stays here while sccb_ready=0. When sccb_ready=1, drive sccb_start=1 for exactly this cycle, clear the timer, go to WAIT_LOW.
- WAIT_LOW: sccb_ready=0 → clear the timer, go to WAIT_HIGH. Timer reaches ACCEPT_TIMEOUT → ERROR.
- WAIT_HIGH: sccb_ready=1 → write_count+1, go to NEXT. Timer reaches XFER_TIMEOUT → ERROR.
- DELAY: decrement to 0, then NEXT. Total DELAY state occupancy is DELAY_CYCLES cycles.
- NEXT:
  - rom_addr = 2^ROM_AW-1 (last entry, no end marker) → DONE; no wrap to 0.
  - Otherwise rom_addr+1 → FETCH.
- DONE: busy=0, done=1, go to IDLE.
- ERROR: busy=0, error=1, go to IDLE. rom_addr holds the failing entry index for debug.
- Latency per write entry: FETCH(1) + DECODE(1) + ISSUE(≥1) + engine transfer + NEXT(1).
- An end marker at address 0 gives done with write_count=0 and no sccb_start pulse.
- A start arriving in the same cycle as DONE/ERROR→IDLE is ignored; start must be presented while in IDLE.

Test Plan (bench parameters: DELAY_CYCLES=20, ACCEPT_TIMEOUT=16, XFER_TIMEOUT=5000; SCCB engine model or real SCCB engine with CLK_FREQ/SCCB_FREQ=40):
- ROM {0x1280, 0x1101, FFFF}, start pulse → two sccb_start pulses carrying (0x12,0x80) then (0x11,0x01), each issued only after ready returned high; then done=1, busy=0, write_count=2.
- ROM {0x1280, FFF0, 0x3A04, FFFF} → exactly 20 cycles in DELAY with no sccb_start between the two writes; done=1, write_count=2.
- ROM[0]=FFFF → done=1 within 4 cycles, no sccb_start, write_count=0.
- Engine model never drops ready after sccb_start → error=1 and busy=0 exactly 16 cycles after WAIT_LOW entry; rom_addr=0; done=0.
- rst_n pulled low mid-transfer in WAIT_HIGH → all outputs zero asynchronously; after release, a new start runs the table from entry 0 with write_count restarting at 0.
- ROM_AW=2, no end marker, 4 write entries → 4 writes, done=1, write_count=4, rom_addr stops at 3; start pulses while busy are ignored (no restart, count unaffected).

Source files
------------

// File: rtl/sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// sccb_config_sequencer
//
// Walks a camera register-init table stored in an external synchronous ROM and
// hands one write per entry to the SCCB write engine. Entry 16'hFFFF ends the
// table, 16'hFFF0 inserts a fixed pause. Both engine handshake phases are
// guarded by timeouts that end the run with a sticky error flag.
//
// Ports:
//   clk, rst_n      system clock (engine domain), async active-low reset
//   start           one-cycle run request, only accepted in IDLE
//   rom_addr        table index; rom_data is valid one cycle after it changes
//   rom_data        {reg_addr, reg_data} or a marker entry
//   sccb_ready      engine idle indication
//   sccb_start      one-cycle write request to the engine
//   sccb_address    register address of the current write
//   sccb_data       register data of the current write
//   busy            run in progress
//   done, error     sticky completion / timeout flags, cleared by next start
//   write_count     writes completed in the current run
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | waiting for start
// S_FETCH     | ROM read latency cycle
// S_DECODE    | classify rom_data: write, delay or end marker
// S_ISSUE     | wait for engine idle, then pulse sccb_start
// S_WAIT_LOW  | wait for engine to accept (ready low), accept timeout
// S_WAIT_HIGH | wait for engine to finish (ready high), transfer timeout
// S_DELAY     | inline pause of DELAY_CYCLES cycles
// S_NEXT      | advance to the next entry or finish at the last address
// S_DONE      | normal completion
// S_ERROR     | handshake timeout; rom_addr keeps the failing entry
// -----------------------------------------------------------------------------
module sccb_config_sequencer #(
    parameter int ROM_AW         = 8,
    parameter int DELAY_CYCLES   = 250000,
    parameter int ACCEPT_TIMEOUT = 16,
    parameter int XFER_TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              sccb_ready,
    output logic              sccb_start,
    output logic [7:0]        sccb_address,
    output logic [7:0]        sccb_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW:0]   write_count
);

    // One down-counter serves the delay and both timeouts; size it for the
    // largest of the three.
    localparam int T_DX  = (DELAY_CYCLES > XFER_TIMEOUT) ? DELAY_CYCLES : XFER_TIMEOUT;
    localparam int T_MAX = (T_DX > ACCEPT_TIMEOUT) ? T_DX : ACCEPT_TIMEOUT;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0]     DELAY_LOAD  = TW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0]     ACCEPT_LOAD = TW'(ACCEPT_TIMEOUT - 1);
    localparam logic [TW-1:0]     XFER_LOAD   = TW'(XFER_TIMEOUT - 1);
    localparam logic [15:0]       ENTRY_END   = 16'hFFFF;
    localparam logic [15:0]       ENTRY_DELAY = 16'hFFF0;
    localparam logic [ROM_AW-1:0] ADDR_LAST   = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              sccb_start_q, sccb_start_d;
    logic [7:0]        sccb_address_q, sccb_address_d;
    logic [7:0]        sccb_data_q, sccb_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ROM_AW:0]   write_count_q, write_count_d;
    logic [TW-1:0]     timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rom_addr_q     <= '0;
            sccb_start_q   <= 1'b0;
            sccb_address_q <= '0;
            sccb_data_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            write_count_q  <= '0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            sccb_start_q   <= sccb_start_d;
            sccb_address_q <= sccb_address_d;
            sccb_data_q    <= sccb_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            write_count_q  <= write_count_d;
            timer_q        <= timer_d;
        end
    end

    // Flag updates are made on the transition into DONE/ERROR so the
    // registered outputs already show the result while in those states.
    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        sccb_start_d   = 1'b0;
        sccb_address_d = sccb_address_q;
        sccb_data_d    = sccb_data_q;
        busy_d         = busy_q;
        done_d         = done_q;
        error_d        = error_q;
        write_count_d  = write_count_q;
        timer_d        = timer_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rom_addr_d    = '0;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    error_d       = 1'b0;
                    write_count_d = '0;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data == ENTRY_END) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rom_data == ENTRY_DELAY) begin
                    timer_d = DELAY_LOAD;
                    state_d = S_DELAY;
                end else begin
                    sccb_address_d = rom_data[15:8];
                    sccb_data_d    = rom_data[7:0];
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sccb_ready) begin
                    sccb_start_d = 1'b1;
                    timer_d      = ACCEPT_LOAD;
                    state_d      = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!sccb_ready) begin
                    timer_d = XFER_LOAD;
                    state_d = S_WAIT_HIGH;
                end else if (timer_q == '0) begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (sccb_ready) begin
                    write_count_d = write_count_q + (ROM_AW+1)'(1);
                    state_d       = S_NEXT;
                end else if (timer_q == '0) begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_DELAY: begin
                if (timer_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_NEXT: begin
                // A full table without an end marker stops at the last entry.
                if (rom_addr_q == ADDR_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    state_d    = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr     = rom_addr_q;
    assign sccb_start   = sccb_start_q;
    assign sccb_address = sccb_address_q;
    assign sccb_data    = sccb_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign write_count  = write_count_q;

endmodule
